// File: rtl/program_loader_if.sv
// Byte-stream, program-memory write port and status signals of the boot-time program loader.
// The host/bench side takes the master modport and the loader takes the slave modport.
interface program_loader_if;
  logic        restart_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        pm_we_o;
  logic [31:0] pm_addr_o;
  logic [31:0] pm_wdata_o;
  logic        core_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  modport master (
    output restart_i, rx_data_i, rx_valid_i,
    input  rx_ready_o, pm_we_o, pm_addr_o, pm_wdata_o,
    input  core_reset_o, busy_o, done_o, error_o
  );

  modport slave (
    input  restart_i, rx_data_i, rx_valid_i,
    output rx_ready_o, pm_we_o, pm_addr_o, pm_wdata_o,
    output core_reset_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: parses a length/data/XOR-checksum byte frame, writes little-endian
// words into program memory and releases the core only after the checksum verifies.
module program_loader #(
  parameter int PROGRAM_MEMORY_DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus
);

  localparam logic [15:0] DEPTH = 16'(PROGRAM_MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_CHECK,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic [7:0]  csum;
  logic        ready;
  logic        accept;
  logic        last_byte;
  logic        last_word;
  logic        word_done;

  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  logic        core_rst_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;

  // Ready is decoded from state so a restart can block the byte in the same cycle.
  assign ready = !bus.restart_i &&
                 (state == S_LEN_LO || state == S_LEN_HI || state == S_DATA || state == S_CSUM);
  assign accept    = bus.rx_valid_i && ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = (word_cnt == len - 16'd1);
  assign word_done = (state == S_DATA) && accept && last_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LEN_LO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.restart_i) begin
      state_nxt = S_LEN_LO;
    end else begin
      case (state)
        S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
        S_LEN_HI: if (accept) state_nxt = S_CHECK;
        S_CHECK: begin
          if (len > DEPTH)       state_nxt = S_ERROR;
          else if (len == 16'd0) state_nxt = S_CSUM;
          else                   state_nxt = S_DATA;
        end
        S_DATA:   if (word_done && last_word) state_nxt = S_CSUM;
        S_CSUM:   if (accept) state_nxt = (bus.rx_data_i == csum) ? S_DONE : S_ERROR;
        S_DONE:   state_nxt = S_DONE;
        S_ERROR:  state_nxt = S_ERROR;
        default:  state_nxt = S_LEN_LO;
      endcase
    end
  end

  // Stage p0: frame parsing, byte assembly and running XOR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      csum     <= '0;
    end else if (bus.restart_i) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      csum     <= '0;
    end else if (accept) begin
      case (state)
        S_LEN_LO: begin
          len[7:0] <= bus.rx_data_i;
          csum     <= csum ^ bus.rx_data_i;
        end
        S_LEN_HI: begin
          len[15:8] <= bus.rx_data_i;
          csum      <= csum ^ bus.rx_data_i;
        end
        S_DATA: begin
          csum     <= csum ^ bus.rx_data_i;
          shreg    <= {bus.rx_data_i, shreg[23:8]};
          byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) word_cnt <= word_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered memory write and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      core_rst_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      vld_p1 <= word_done;
      if (word_done) begin
        addr_p1  <= {14'd0, word_cnt, 2'b00};
        wdata_p1 <= {bus.rx_data_i, shreg};
      end
      core_rst_r <= (state_nxt == S_DONE);
      done_r     <= (state_nxt == S_DONE);
      error_r    <= (state_nxt == S_ERROR);
      busy_r     <= (state_nxt == S_LEN_HI) || (state_nxt == S_CHECK) ||
                    (state_nxt == S_DATA)   || (state_nxt == S_CSUM);
    end
  end

  assign bus.rx_ready_o   = ready;
  assign bus.pm_we_o      = vld_p1;
  assign bus.pm_addr_o    = addr_p1;
  assign bus.pm_wdata_o   = wdata_p1;
  assign bus.core_reset_o = core_rst_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.error_o      = error_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames for program_loader, checked against a frame-level model that
// derives the expected writes and verdict directly from the byte list.
module tb_program_loader;
  typedef logic [7:0] u8;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  u8           frame[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] save_q[$];
  bit          exp_done;
  bit          exp_err;
  bit          exp_over;

  program_loader_if bus();

  program_loader #(.PROGRAM_MEMORY_DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && bus.pm_we_o) got_q.push_back({bus.pm_addr_o, bus.pm_wdata_o});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    logic [15:0] n16;
    u8 x;
    u8 b;
    n16 = 16'(n);
    frame.delete();
    frame.push_back(n16[7:0]);
    frame.push_back(n16[15:8]);
    x = n16[7:0] ^ n16[15:8];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
    frame.push_back(x);
  endtask

  // Frame-level expectation: word k is bytes 2+4k..2+4k+3 little-endian at byte address 4k.
  task automatic model();
    int n;
    u8  x;
    exp_q.delete();
    n = int'({frame[1], frame[0]});
    exp_over = (n > 64);
    if (exp_over) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      for (int k = 0; k < n; k++)
        exp_q.push_back({32'(4 * k), frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]});
      x = 8'h00;
      for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
      exp_done = (frame[frame.size()-1] == x);
      exp_err  = !exp_done;
    end
  endtask

  task automatic send_bytes(input bit throttle);
    int i = 0;
    int cyc = 0;
    bit acc;
    while (i < frame.size() && cyc < 4000) begin
      @(negedge clk);
      bus.rx_valid_i = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rx_data_i  = frame[i];
      #1 acc = bus.rx_valid_i && bus.rx_ready_o;
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    check("bytes_accepted", 64'(i), 64'(frame.size()));
  endtask

  task automatic run_frame(input string tag, input bit throttle);
    got_q.delete();
    model();
    send_bytes(throttle);
    if (exp_over) @(negedge clk);
    check({tag, "_done"},  64'(bus.done_o),       64'(exp_done));
    check({tag, "_core"},  64'(bus.core_reset_o), 64'(exp_done));
    check({tag, "_err"},   64'(bus.error_o),      64'(exp_err));
    check({tag, "_busy"},  64'(bus.busy_o),       64'd0);
    check({tag, "_ready"}, 64'(bus.rx_ready_o),   64'd0);
    check({tag, "_nwr"},   64'(got_q.size()),     64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.restart_i = 1'b1;
    #1 check("restart_ready", 64'(bus.rx_ready_o), 64'd0);
    @(negedge clk);
    bus.restart_i = 1'b0;
    #1;
    check("restart_done", 64'(bus.done_o),       64'd0);
    check("restart_core", 64'(bus.core_reset_o), 64'd0);
    check("restart_err",  64'(bus.error_o),      64'd0);
    check("restart_rdy1", 64'(bus.rx_ready_o),   64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    64'(bus.pm_we_o),      64'd0);
    check({tag, "_addr"},  64'(bus.pm_addr_o),    64'd0);
    check({tag, "_wdata"}, 64'(bus.pm_wdata_o),   64'd0);
    check({tag, "_core"},  64'(bus.core_reset_o), 64'd0);
    check({tag, "_busy"},  64'(bus.busy_o),       64'd0);
    check({tag, "_done"},  64'(bus.done_o),       64'd0);
    check({tag, "_err"},   64'(bus.error_o),      64'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.restart_i  = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    #1 check("rst_ready", 64'(bus.rx_ready_o), 64'd1);

    // single good word
    frame = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    run_frame("good1", 1'b0);
    check("good1_word", (got_q.size() > 0) ? got_q[0] : 64'hDEAD, {32'h0, 32'h00500093});
    check("good1_done_const", 64'(bus.done_o), 64'd1);

    // bad checksum
    do_restart();
    frame = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    run_frame("badcs", 1'b0);
    check("badcs_err_const", 64'(bus.error_o), 64'd1);

    // oversize count
    do_restart();
    frame = {8'h41, 8'h00};
    run_frame("over", 1'b0);

    // zero-length frame
    do_restart();
    frame = {8'h00, 8'h00, 8'h00};
    run_frame("zero", 1'b0);

    // N=3 unthrottled, then identical frame throttled
    do_restart();
    build_frame(3, 1'b0);
    run_frame("n3_fast", 1'b0);
    save_q = got_q;
    do_restart();
    run_frame("n3_slow", 1'b1);
    check("n3_same_n", 64'(got_q.size()), 64'(save_q.size()));
    for (int i = 0; i < save_q.size() && i < got_q.size(); i++)
      check("n3_same_wr", got_q[i], save_q[i]);

    // maximum legal depth
    do_restart();
    build_frame(64, 1'b0);
    run_frame("n64", 1'b0);

    // restart after DONE then reload
    do_restart();
    build_frame(2, 1'b0);
    run_frame("reload", 1'b1);

    // reset after two data bytes
    do_restart();
    got_q.delete();
    frame = {8'h01, 8'h00, 8'h93, 8'h00};
    send_bytes(1'b0);
    reset = 1'b0;
    #1 check_reset_values("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_nowrite", 64'(got_q.size()), 64'd0);
    build_frame(1, 1'b0);
    run_frame("after_rst", 1'b0);

    // randomized frames
    for (int t = 0; t < 8; t++) begin
      do_restart();
      build_frame($urandom_range(1, 8), 1'($urandom_range(0, 3) == 0));
      run_frame("rand", 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
